// File: rtl/aca_err_monitor.sv
// Error-characterisation monitor for 8-bit approximate adders: compares each approximate sum
// against the exact sum and reports per-window error count, distance sum and maximum distance.
module aca_err_monitor #(
  parameter int unsigned W       = 8,
  parameter int unsigned SAMPLES = 256,
  parameter int unsigned CW      = $clog2(SAMPLES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W:0]      approx_sum,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CW-1:0]   err_count,
  output logic [W+CW:0]   ed_sum,
  output logic [W:0]      ed_max
);

  localparam logic [0:0]    ST_ACCUM   = 1'b0;
  localparam logic [0:0]    ST_REPORT  = 1'b1;
  localparam logic [CW-1:0] LP_SAMPLES = CW'(SAMPLES);
  localparam logic [CW-1:0] LP_LAST    = CW'(SAMPLES - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_acc_cnt;
  logic [CW-1:0] r_proc_cnt;
  logic          r_s1_valid;
  logic [W:0]    r_s1_ed;
  logic          r_s1_err;
  logic [CW-1:0] r_err_count;
  logic [W+CW:0] r_ed_sum;
  logic [W:0]    r_ed_max;

  logic [W:0]    w_exact;
  logic [W:0]    w_ed;
  logic          w_accept;
  logic          w_drain;
  logic          w_last;

  // Operands are widened before the add so the carry-out is kept.
  assign w_exact  = {1'b0, a} + {1'b0, b};
  assign w_ed     = (w_exact >= approx_sum) ? (w_exact - approx_sum) : (approx_sum - w_exact);

  assign in_ready = (r_state == ST_ACCUM) && (r_acc_cnt < LP_SAMPLES);
  assign w_accept = in_valid && in_ready;
  assign w_drain  = res_valid && res_ready;
  assign w_last   = r_s1_valid && (r_proc_cnt == LP_LAST);

  assign res_valid = (r_state == ST_REPORT);
  assign err_count = r_err_count;
  assign ed_sum    = r_ed_sum;
  assign ed_max    = r_ed_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc_cnt   <= '0;
      r_proc_cnt  <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_ed     <= '0;
      r_s1_err    <= 1'b0;
      r_err_count <= '0;
      r_ed_sum    <= '0;
      r_ed_max    <= '0;
    end else if (clear || w_drain) begin
      r_state     <= ST_ACCUM;
      r_acc_cnt   <= '0;
      r_proc_cnt  <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_ed     <= '0;
      r_s1_err    <= 1'b0;
      r_err_count <= '0;
      r_ed_sum    <= '0;
      r_ed_max    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ed   <= w_ed;
        r_s1_err  <= |w_ed;
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      // Stage 2: fold the registered sample into the window statistics.
      if (r_s1_valid) begin
        r_ed_sum    <= r_ed_sum + {{CW{1'b0}}, r_s1_ed};
        r_err_count <= r_err_count + CW'(r_s1_err);
        if (r_s1_ed > r_ed_max) begin
          r_ed_max <= r_s1_ed;
        end
        r_proc_cnt <= r_proc_cnt + 1'b1;
        if (w_last) begin
          r_state <= ST_REPORT;
        end
      end
    end
  end

endmodule

// File: tb/tb_aca_err_monitor.sv
// Randomized and directed bench for aca_err_monitor (W=8, SAMPLES=4) against a
// window-level reference model built from lists of error distances.
module tb_aca_err_monitor;

  localparam int W  = 8;
  localparam int S  = 4;
  localparam int CW = $clog2(S + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic [W:0]      approx_sum = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [CW-1:0]   err_count;
  logic [W+CW:0]   ed_sum;
  logic [W:0]      ed_max;

  aca_err_monitor #(.W(W), .SAMPLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .err_count  (err_count),
    .ed_sum     (ed_sum),
    .ed_max     (ed_max)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: a window is a list of error distances already folded into the stats,
  // plus at most one accepted sample still in flight.
  bit m_report;
  int m_acc;
  bit m_pend_v;
  int m_pend_ed;
  int m_eds[$];

  function automatic void model_reset();
    m_report  = 1'b0;
    m_acc     = 0;
    m_pend_v  = 1'b0;
    m_pend_ed = 0;
    m_eds.delete();
  endfunction

  function automatic int abs_ed(input int x, input int y, input int s);
    int d;
    d = x + y - s;
    return (d < 0) ? -d : d;
  endfunction

  task automatic check_outputs(input string tag);
    int ec, es, em;
    ec = 0; es = 0; em = 0;
    foreach (m_eds[i]) begin
      if (m_eds[i] != 0) ec++;
      es += m_eds[i];
      if (m_eds[i] > em) em = m_eds[i];
    end
    check({tag, ".res_valid"}, 32'(res_valid), 32'(m_report));
    check({tag, ".in_ready"},  32'(in_ready),  32'(!m_report && (m_acc < S)));
    check({tag, ".err_count"}, 32'(err_count), ec);
    check({tag, ".ed_sum"},    32'(ed_sum),    es);
    check({tag, ".ed_max"},    32'(ed_max),    em);
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = !m_report && (m_acc < S);
    if (clear) begin
      model_reset();
    end else if (m_report) begin
      if (res_ready) model_reset();
    end else begin
      if (m_pend_v) begin
        m_eds.push_back(m_pend_ed);
        if (m_eds.size() == S) m_report = 1'b1;
      end
      m_pend_v = in_valid && rdy;
      if (m_pend_v) begin
        m_pend_ed = abs_ed(int'(a), int'(b), int'(approx_sum));
        m_acc++;
      end
    end
  endtask

  task automatic tick(input string tag);
    check_outputs(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input int va, input int vb, input int vs);
    in_valid   = 1'b1;
    a          = W'(va);
    b          = W'(vb);
    approx_sum = (W+1)'(vs);
    tick(tag);
  endtask

  task automatic idle(input string tag, input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick(tag);
    res_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk);
    #1;

    // Exact window.
    for (int i = 0; i < S; i++) send("exact", 3, 5, 9'h008);
    idle("exact_wait", 1);
    check("exact_res_valid", 32'(res_valid), 1);
    check("exact_err_count", 32'(err_count), 0);
    check("exact_ed_sum",    32'(ed_sum),    0);
    drain("exact_drain");

    // Mixed errors, then backpressure while in REPORT.
    send("mixed", 8'h0F, 8'h01, 9'h000);
    send("mixed", 8'h10, 8'h00, 9'h110);
    send("mixed", 8'h20, 8'h22, 9'h042);
    send("mixed", 8'hFF, 8'h01, 9'h100);
    idle("mixed_wait", 1);
    check("mixed_err_count", 32'(err_count), 2);
    check("mixed_ed_sum",    32'(ed_sum),    272);
    check("mixed_ed_max",    32'(ed_max),    256);
    for (int i = 0; i < 5; i++) send("bp", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_ed_sum",   32'(ed_sum),   272);
    drain("bp_drain");
    check("bp_after_res_valid", 32'(res_valid), 0);
    check("bp_after_ed_sum",    32'(ed_sum),    0);
    idle("bp_idle", 1);

    // Maximum error distance every sample.
    for (int i = 0; i < S; i++) send("maxerr", 8'hFF, 8'hFF, 9'h000);
    idle("maxerr_wait", 1);
    check("maxerr_err_count", 32'(err_count), 4);
    check("maxerr_ed_sum",    32'(ed_sum),    2040);
    check("maxerr_ed_max",    32'(ed_max),    510);
    drain("maxerr_drain");

    // Clear aborts a partial window; the same-cycle sample is discarded.
    send("clr", 8'h0F, 8'h01, 9'h000);
    send("clr", 8'h10, 8'h00, 9'h110);
    clear = 1'b1;
    send("clr_edge", 8'hFF, 8'hFF, 9'h000);
    clear = 1'b0;
    idle("clr_after", 1);
    check("clr_err_count", 32'(err_count), 0);
    check("clr_ed_sum",    32'(ed_sum),    0);
    for (int i = 0; i < S; i++) send("clr_win", 8'h01, 8'h01, 9'h001);
    idle("clr_win_wait", 1);
    check("clr_win_err_count", 32'(err_count), 4);
    check("clr_win_ed_sum",    32'(ed_sum),    4);

    // Asynchronous reset while in REPORT.
    #3 rst = 1'b1;
    #1;
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_ed_sum",    32'(ed_sum),    0);
    check("rst_ed_max",    32'(ed_max),    0);
    model_reset();
    #2 rst = 1'b0;
    idle("rst_release", 1);
    check("rst_in_ready", 32'(in_ready), 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int va, vb, vs;
      va = int'($urandom_range(0, 255));
      vb = int'($urandom_range(0, 255));
      vs = ($urandom_range(0, 1) == 0) ? (va + vb) : int'($urandom_range(0, 511));
      clear     = ($urandom_range(0, 19) == 0);
      res_ready = ($urandom_range(0, 2) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      a          = W'(va);
      b          = W'(vb);
      approx_sum = (W+1)'(vs);
      tick("rand");
    end
    clear     = 1'b0;
    res_ready = 1'b0;
    idle("final", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
